// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order core slice: ROB sizing, register and PC
// widths, and the packed reorder-buffer entry.
package ooo_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = 4;
  localparam int PREG_W    = 7;
  localparam int PC_W      = 9;
  localparam int AREG_W    = 5;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [PREG_W-1:0]    preg_t;
  typedef logic [AREG_W-1:0]    areg_t;
  typedef logic [PC_W-1:0]      pc_t;

  // One in-flight instruction, from dispatch to retirement.
  typedef struct packed {
    logic  valid;
    logic  done;
    logic  mispredict;
    logic  is_branch;
    logic  reg_write;
    areg_t rd;
    preg_t prd;
    preg_t old_prd;
    pc_t   pc;
  } rob_entry_t;

endpackage : ooo_pkg

// File: rtl/reorder_buffer.sv
// In-order retirement queue sitting behind rename. It allocates one entry per
// cycle at the tail, marks entries done from writeback, and retires one entry
// per cycle from the head. Retiring a mispredicted branch flushes every younger
// entry and pulses branch_mispredict.
// The entry storage uses ooo_pkg::rob_entry_t, so the width parameters must
// match the package constants.
// Optional build macro: ROB_STATS_EN adds saturating retire and full-stall
// counters (stat_retired, stat_full_stalls).
module reorder_buffer #(
  parameter int DEPTH  = ooo_pkg::ROB_DEPTH,
  parameter int TAG_W  = ooo_pkg::ROB_TAG_W,
  parameter int PREG_W = ooo_pkg::PREG_W,
  parameter int PC_W   = ooo_pkg::PC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [4:0]        alloc_rd,
  input  logic [PREG_W-1:0] alloc_prd,
  input  logic [PREG_W-1:0] alloc_old_prd,
  input  logic              alloc_reg_write,
  input  logic              alloc_is_branch,
  input  logic [PC_W-1:0]   alloc_pc,
  output logic [TAG_W-1:0]  rob_tail_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic              wb_mispredict,
  output logic              retire_valid,
  output logic [PC_W-1:0]   retire_pc,
  output logic              commit_en,
  output logic [PREG_W-1:0] commit_old_preg,
  output logic [4:0]        commit_rd,
  output logic [PREG_W-1:0] commit_prd,
  output logic              branch_mispredict,
  output logic              empty,
  output logic              full
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]       stat_retired,
  output logic [31:0]       stat_full_stalls
`endif
);

  import ooo_pkg::*;

  localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   COUNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);

  rob_entry_t       entries [DEPTH];
  rob_entry_t       head_entry;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  logic retire_now;
  logic flush_now;
  logic alloc_fire;
  logic wb_fire;

  assign head_entry   = entries[head];
  assign rob_tail_tag = tail;
  assign full         = (count == FULL_COUNT);
  assign empty        = (count == '0);
  assign alloc_ready  = !full && !flush_now;

  // Decode this cycle's retire, flush, allocate and writeback events.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    retire_now = 1'b0;
    flush_now  = 1'b0;
    alloc_fire = 1'b0;
    wb_fire    = 1'b0;
    if (head_entry.valid && head_entry.done) begin
      retire_now = 1'b1;
      flush_now  = head_entry.mispredict;
    end
    alloc_fire = alloc_valid && !full && !flush_now;
    // A flush discards any completion arriving in the same cycle.
    wb_fire    = wb_valid && entries[wb_tag].valid && !flush_now;
  end

  // Head/tail pointers and occupancy; a flush restarts both pointers just past the retiring branch.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_now) begin
      head  <= head + TAG_ONE;
      tail  <= head + TAG_ONE;
      count <= '0;
    end else begin
      if (retire_now) head <= head + TAG_ONE;
      if (alloc_fire) tail <= tail + TAG_ONE;
      case ({alloc_fire, retire_now})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry array with per-entry write enables for allocate, writeback, retire and flush.
  // NOTE: the whole entry array is reset because the valid/done/mispredict bits must clear; the array is small enough that a reset on every field costs little.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_now) begin
          entries[i].valid <= 1'b0;
        end else begin
          if (wb_fire && wb_tag == TAG_W'(i)) begin
            entries[i].done <= 1'b1;
            if (wb_mispredict && entries[i].is_branch) entries[i].mispredict <= 1'b1;
          end
          if (retire_now && head == TAG_W'(i)) entries[i].valid <= 1'b0;
          // The tail slot is never the retiring head: that would need count==DEPTH, which blocks allocation.
          if (alloc_fire && tail == TAG_W'(i)) begin
            entries[i] <= '{valid:      1'b1,
                            done:       1'b0,
                            mispredict: 1'b0,
                            is_branch:  alloc_is_branch,
                            reg_write:  alloc_reg_write,
                            rd:         alloc_rd,
                            prd:        alloc_prd,
                            old_prd:    alloc_old_prd,
                            pc:         alloc_pc};
          end
        end
      end
    end
  end

  // Registered retire/commit pulses; payloads are zero in cycles without a retire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_valid      <= 1'b0;
      retire_pc         <= '0;
      commit_en         <= 1'b0;
      commit_old_preg   <= '0;
      commit_rd         <= '0;
      commit_prd        <= '0;
      branch_mispredict <= 1'b0;
    end else begin
      retire_valid      <= retire_now;
      retire_pc         <= retire_now ? head_entry.pc      : '0;
      commit_old_preg   <= retire_now ? head_entry.old_prd : '0;
      commit_rd         <= retire_now ? head_entry.rd      : '0;
      commit_prd        <= retire_now ? head_entry.prd     : '0;
      // x0 is never renamed, so a write to rd 0 frees nothing.
      commit_en         <= retire_now && head_entry.reg_write && (head_entry.rd != '0);
      branch_mispredict <= flush_now;
    end
  end

`ifdef ROB_STATS_EN
  // Saturating retire and full-stall counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_retired     <= '0;
      stat_full_stalls <= '0;
    end else begin
      if (retire_now && stat_retired != '1) stat_retired <= stat_retired + 32'd1;
      if (alloc_valid && full && stat_full_stalls != '1) stat_full_stalls <= stat_full_stalls + 32'd1;
    end
  end
`endif

endmodule : reorder_buffer

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue of expected retirements is filled
// as instructions are dispatched and drained as retire pulses appear.
module tb_reorder_buffer;

  logic       clk;
  logic       reset;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [4:0] alloc_rd;
  logic [6:0] alloc_prd;
  logic [6:0] alloc_old_prd;
  logic       alloc_reg_write;
  logic       alloc_is_branch;
  logic [8:0] alloc_pc;
  logic [3:0] rob_tail_tag;
  logic       wb_valid;
  logic [3:0] wb_tag;
  logic       wb_mispredict;
  logic       retire_valid;
  logic [8:0] retire_pc;
  logic       commit_en;
  logic [6:0] commit_old_preg;
  logic [4:0] commit_rd;
  logic [6:0] commit_prd;
  logic       branch_mispredict;
  logic       empty;
  logic       full;
`ifdef ROB_STATS_EN
  logic [31:0] stat_retired;
  logic [31:0] stat_full_stalls;
`endif

  typedef struct {
    logic [8:0] pc;
    logic [4:0] rd;
    logic [6:0] prd;
    logic [6:0] old_prd;
    logic       commit_en;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  reorder_buffer dut (
    .clk               (clk),
    .reset             (reset),
    .alloc_valid       (alloc_valid),
    .alloc_ready       (alloc_ready),
    .alloc_rd          (alloc_rd),
    .alloc_prd         (alloc_prd),
    .alloc_old_prd     (alloc_old_prd),
    .alloc_reg_write   (alloc_reg_write),
    .alloc_is_branch   (alloc_is_branch),
    .alloc_pc          (alloc_pc),
    .rob_tail_tag      (rob_tail_tag),
    .wb_valid          (wb_valid),
    .wb_tag            (wb_tag),
    .wb_mispredict     (wb_mispredict),
    .retire_valid      (retire_valid),
    .retire_pc         (retire_pc),
    .commit_en         (commit_en),
    .commit_old_preg   (commit_old_preg),
    .commit_rd         (commit_rd),
    .commit_prd        (commit_prd),
    .branch_mispredict (branch_mispredict),
    .empty             (empty),
    .full              (full)
`ifdef ROB_STATS_EN
    ,
    .stat_retired      (stat_retired),
    .stat_full_stalls  (stat_full_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one allocation for the coming edge; optionally record its retirement.
  task automatic set_alloc(input logic [4:0] rd, input logic [6:0] prd, input logic [6:0] old_prd,
                           input logic rw, input logic br, input logic [8:0] pc,
                           input int exp_tag, input bit will_retire);
    exp_t e;
    check("alloc_ready", alloc_ready, 1);
    check("alloc_tag", rob_tail_tag, exp_tag);
    alloc_valid     = 1'b1;
    alloc_rd        = rd;
    alloc_prd       = prd;
    alloc_old_prd   = old_prd;
    alloc_reg_write = rw;
    alloc_is_branch = br;
    alloc_pc        = pc;
    if (will_retire) begin
      e.pc        = pc;
      e.rd        = rd;
      e.prd       = prd;
      e.old_prd   = old_prd;
      e.commit_en = rw && (rd != 5'd0);
      exp_q.push_back(e);
    end
  endtask

  task automatic set_wb(input logic [3:0] tag, input logic mp);
    wb_valid      = 1'b1;
    wb_tag        = tag;
    wb_mispredict = mp;
  endtask

  // Advance one clock, release one-shot inputs, and score any retirement.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    alloc_valid   = 1'b0;
    wb_valid      = 1'b0;
    wb_mispredict = 1'b0;
    if (retire_valid) begin
      check("retire_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("retire_pc", retire_pc, e.pc);
        check("commit_rd", commit_rd, e.rd);
        check("commit_prd", commit_prd, e.prd);
        check("commit_old_preg", commit_old_preg, e.old_prd);
        check("commit_en", commit_en, e.commit_en);
      end
    end else begin
      check("commit_en_idle", commit_en, 0);
    end
  endtask

  // Pulse reset between edges and confirm everything clears immediately.
  task automatic pulse_reset();
    #1;
    reset = 1'b0;
    #1;
    check("rst_retire_valid", retire_valid, 0);
    check("rst_commit_en", commit_en, 0);
    check("rst_retire_pc", retire_pc, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_branch_mispredict", branch_mispredict, 0);
    reset = 1'b1;
    #1;
    check("rst_tail_tag", rob_tail_tag, 0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b0;
    alloc_valid = 1'b0; alloc_rd = '0; alloc_prd = '0; alloc_old_prd = '0;
    alloc_reg_write = 1'b0; alloc_is_branch = 1'b0; alloc_pc = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_mispredict = 1'b0;

    // Reset state.
    #1;
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_alloc_ready", alloc_ready, 1);
    check("reset_tail_tag", rob_tail_tag, 0);
    check("reset_retire_valid", retire_valid, 0);
    check("reset_branch_mispredict", branch_mispredict, 0);
    #11;
    reset = 1'b1;

    // Out-of-order completion, in-order retirement.
    set_alloc(5'd1, 7'd33, 7'd10, 1'b1, 1'b0, 9'h100, 0, 1); tick();
    set_alloc(5'd2, 7'd34, 7'd11, 1'b0, 1'b0, 9'h104, 1, 1); tick();
    set_alloc(5'd3, 7'd35, 7'd12, 1'b1, 1'b0, 9'h108, 2, 1); tick();
    set_wb(4'd2, 1'b0); tick();
    set_wb(4'd0, 1'b0); tick();
    set_wb(4'd1, 1'b0); tick();
    tick(); tick(); tick();
    check("inorder_drained", exp_q.size(), 0);
    check("inorder_empty", empty, 1);

    // Fill to DEPTH, retire one, confirm the slot opens a cycle later and the tag wraps.
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      set_alloc(5'(i + 1), 7'(64 + i), 7'(i), 1'b1, 1'b0, 9'(9'h40 + i), i, (i == 0));
      tick();
    end
    check("fill_full", full, 1);
    check("fill_alloc_ready", alloc_ready, 0);
    check("fill_empty", empty, 0);
    set_wb(4'd0, 1'b0);
    alloc_valid = 1'b1; alloc_pc = 9'h1FF;
    tick();
    check("full_after_wb", full, 1);
    alloc_valid = 1'b1; alloc_pc = 9'h1FE;
    tick();
    check("full_drops", full, 0);
    check("full_drop_ready", alloc_ready, 1);
    check("full_retired_one", exp_q.size(), 0);
    set_alloc(5'd5, 7'd99, 7'd98, 1'b1, 1'b0, 9'h050, 0, 0); tick();
    check("wrap_full_again", full, 1);
    check("wrap_tail_tag", rob_tail_tag, 1);

    // Write to x0 retires without freeing a register.
    pulse_reset();
    set_alloc(5'd0, 7'd20, 7'd21, 1'b1, 1'b0, 9'h060, 0, 1); tick();
    set_wb(4'd0, 1'b0); tick();
    tick();
    check("x0_retired", exp_q.size(), 0);
    tick();
    check("x0_empty", empty, 1);

    // Mispredicted branch at tag 3 flushes tags 4 and 5.
    set_alloc(5'd7, 7'd45, 7'd50, 1'b1, 1'b0, 9'h0A0, 1, 1); tick();
    set_alloc(5'd8, 7'd46, 7'd51, 1'b1, 1'b0, 9'h0A4, 2, 1); set_wb(4'd1, 1'b0); tick();
    set_alloc(5'd0, 7'd0, 7'd0, 1'b0, 1'b1, 9'h0C0, 3, 1); set_wb(4'd2, 1'b0); tick();
    set_alloc(5'd9, 7'd47, 7'd40, 1'b1, 1'b0, 9'h0C4, 4, 0); tick();
    set_alloc(5'd10, 7'd48, 7'd41, 1'b1, 1'b0, 9'h0C8, 5, 0); tick();
    set_wb(4'd5, 1'b0); tick();
    set_wb(4'd4, 1'b0); tick();
    set_wb(4'd3, 1'b1); tick();
    check("flush_blocks_alloc", alloc_ready, 0);
    alloc_valid = 1'b1; alloc_pc = 9'h1F0;
    set_wb(4'd4, 1'b0);
    tick();
    check("flush_pulse", branch_mispredict, 1);
    check("flush_empty", empty, 1);
    check("flush_tail_tag", rob_tail_tag, 4);
    check("flush_branch_retired", exp_q.size(), 0);
    tick();
    check("flush_pulse_ends", branch_mispredict, 0);
    tick(); tick();
    check("flush_still_empty", empty, 1);

    // Asynchronous reset mid-cycle with five valid entries and a retire pulse live.
    for (int i = 0; i < 6; i++) begin
      set_alloc(5'(11 + i), 7'(50 + i), 7'(60 + i), 1'b1, 1'b0, 9'(9'h100 + i), 4 + i, 1);
      if (i == 5) set_wb(4'd4, 1'b0);
      tick();
    end
    tick();
    check("pre_reset_retire", retire_valid, 1);
    check("pre_reset_commit", commit_en, 1);
    check("pre_reset_not_empty", empty, 0);
    pulse_reset();

    // Steady stream: one alloc and one retire per cycle without stalling.
    for (int i = 0; i < 10; i++) begin
      set_alloc(5'(i + 1), 7'(80 + i), 7'(20 + i), 1'b1, 1'b0, 9'(9'h180 + i), i, 1);
      if (i > 0) set_wb(4'(i - 1), 1'b0);
      tick();
      if (i >= 2) begin
        check("stream_retire", retire_valid, 1);
        check("stream_not_full", full, 0);
      end
    end
    set_wb(4'd9, 1'b0); tick();
    tick();
    check("stream_drained", exp_q.size(), 0);
    check("stream_empty", empty, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_reorder_buffer
